spi_master_ctrl: RTL

//  Master-mode SPI transfer sequencer behind the APB slave register interface.

---
 rtl/spi_master_ctrl_if.sv | 37 +++
 rtl/spi_master_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/spi_master_ctrl_if.sv
// Bundle of configuration, strobe and serial-line signals between the APB
// register block and the SPI master transfer sequencer.
// The "master" modport is the sequencer's view (it owns the SPI lines);
// the "slave" modport is the register-block / environment view.
interface spi_master_ctrl_if #(
  parameter int DW = 8
);
  logic          mstr;
  logic          cpol;
  logic          cpha;
  logic          lsbfe;
  logic [2:0]    sppr;
  logic [2:0]    spr;
  logic [1:0]    spi_mode;
  logic          spiswai;
  logic          send_data;
  logic [DW-1:0] tx_data;
  logic          miso;
  logic          sclk;
  logic          ss;
  logic          mosi;
  logic          tip;
  logic          receive_data;
  logic [DW-1:0] rx_data;

  modport master (
    input  mstr, cpol, cpha, lsbfe, sppr, spr, spi_mode, spiswai,
           send_data, tx_data, miso,
    output sclk, ss, mosi, tip, receive_data, rx_data
  );

  modport slave (
    output mstr, cpol, cpha, lsbfe, sppr, spr, spi_mode, spiswai,
           send_data, tx_data, miso,
    input  sclk, ss, mosi, tip, receive_data, rx_data
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI master transfer sequencer: baud-divided SCLK generation, SS framing,
// MOSI shifting and MISO sampling for one DW-bit frame per send_data strobe.
// Frame configuration is latched at frame start so register writes during a
// frame only affect the next one.
module spi_master_ctrl #(
  parameter int DW = 8
) (
  input logic               PCLK,
  input logic               PRESET,
  spi_master_ctrl_if.master bus
);

  localparam int EW = $clog2(2*DW + 1);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2*DW - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    TRANSFER,
    HOLD
  } state_t;

  state_t        r_state;
  logic [9:0]    r_hcnt;
  logic [9:0]    r_half;
  logic [EW-1:0] r_edgeCnt;
  logic          r_cpol;
  logic          r_cpha;
  logic          r_lsbfe;
  logic [DW-1:0] r_txShift;
  logic [DW-1:0] r_rxShift;
  logic          r_sclk;
  logic          r_ss;
  logic          r_mosi;
  logic          r_tip;
  logic          r_rxValid;
  logic [DW-1:0] r_rxData;

  logic [9:0]    w_halfM1;
  logic          w_freeze;
  logic          w_abort;
  logic          w_start;
  logic          w_intervalEnd;
  logic          w_leading;
  logic          w_lastEdge;
  logic          w_sample;
  logic          w_drive;

  // Bit that goes on the wire next for the given bit order.
  function automatic logic headBit(input logic [DW-1:0] data, input logic lsbFirst);
    return lsbFirst ? data[0] : data[DW-1];
  endfunction

  // Drop the bit just sent so the next one sits at the head.
  function automatic logic [DW-1:0] advance(input logic [DW-1:0] data, input logic lsbFirst);
    return lsbFirst ? (data >> 1) : (data << 1);
  endfunction

  // Half SCLK period minus one, (sppr+1) << spr spans 1..1024 so this fits 10 bits.
  assign w_halfM1 = 10'((({8'd0, bus.sppr} + 11'd1) << bus.spr) - 11'd1);

  assign w_freeze      = (bus.spi_mode == 2'b01) && bus.spiswai;
  assign w_abort       = bus.spi_mode[1] || !bus.mstr;
  assign w_start       = bus.send_data && bus.mstr && !bus.spi_mode[1];
  assign w_intervalEnd = (r_hcnt == r_half);
  // Toggle number r_edgeCnt+1 is odd (a leading edge) when the count is even.
  assign w_leading     = ~r_edgeCnt[0];
  assign w_lastEdge    = (r_edgeCnt == LAST_EDGE);
  assign w_sample      = w_leading ^ r_cpha;
  assign w_drive       = r_cpha ? w_leading : (!w_leading && !w_lastEdge);

  // Frame sequencer with all outputs registered; abort beats freeze, freeze beats progress.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state   <= IDLE;
      r_hcnt    <= '0;
      r_half    <= '0;
      r_edgeCnt <= '0;
      r_cpol    <= 1'b0;
      r_cpha    <= 1'b0;
      r_lsbfe   <= 1'b0;
      r_txShift <= '0;
      r_rxShift <= '0;
      r_sclk    <= 1'b0;
      r_ss      <= 1'b1;
      r_mosi    <= 1'b0;
      r_tip     <= 1'b0;
      r_rxValid <= 1'b0;
      r_rxData  <= '0;
    end else begin
      r_rxValid <= 1'b0;
      if (r_state != IDLE && w_abort) begin
        r_state   <= IDLE;
        r_ss      <= 1'b1;
        r_tip     <= 1'b0;
        r_sclk    <= bus.cpol;
        r_hcnt    <= '0;
        r_edgeCnt <= '0;
      end else if (!w_freeze) begin
        unique case (r_state)
          IDLE: begin
            r_sclk <= bus.cpol;
            if (w_start) begin
              r_state   <= SETUP;
              r_ss      <= 1'b0;
              r_tip     <= 1'b1;
              r_hcnt    <= '0;
              r_edgeCnt <= '0;
              r_half    <= w_halfM1;
              r_cpol    <= bus.cpol;
              r_cpha    <= bus.cpha;
              r_lsbfe   <= bus.lsbfe;
              r_rxShift <= '0;
              if (!bus.cpha) begin
                r_mosi    <= headBit(bus.tx_data, bus.lsbfe);
                r_txShift <= advance(bus.tx_data, bus.lsbfe);
              end else begin
                r_txShift <= bus.tx_data;
              end
            end
          end
          SETUP: begin
            if (w_intervalEnd) begin
              r_state <= TRANSFER;
              r_hcnt  <= '0;
            end else begin
              r_hcnt <= r_hcnt + 10'd1;
            end
          end
          TRANSFER: begin
            if (w_intervalEnd) begin
              r_hcnt    <= '0;
              r_sclk    <= w_lastEdge ? r_cpol : ~r_sclk;
              r_edgeCnt <= w_lastEdge ? '0 : r_edgeCnt + EW'(1);
              if (w_sample) begin
                r_rxShift <= r_lsbfe ? {bus.miso, r_rxShift[DW-1:1]}
                                     : {r_rxShift[DW-2:0], bus.miso};
              end
              if (w_drive) begin
                r_mosi    <= headBit(r_txShift, r_lsbfe);
                r_txShift <= advance(r_txShift, r_lsbfe);
              end
              if (w_lastEdge) begin
                r_state <= HOLD;
              end
            end else begin
              r_hcnt <= r_hcnt + 10'd1;
            end
          end
          HOLD: begin
            if (w_intervalEnd) begin
              r_state   <= IDLE;
              r_hcnt    <= '0;
              r_ss      <= 1'b1;
              r_tip     <= 1'b0;
              r_rxValid <= 1'b1;
              r_rxData  <= r_rxShift;
            end else begin
              r_hcnt <= r_hcnt + 10'd1;
            end
          end
        endcase
      end
    end
  end

  assign bus.sclk         = r_sclk;
  assign bus.ss           = r_ss;
  assign bus.mosi         = r_mosi;
  assign bus.tip          = r_tip;
  assign bus.receive_data = r_rxValid;
  assign bus.rx_data      = r_rxData;

endmodule
